mux8_rr_arbiter: RTL and testbench
==================================

Name: mux8_rr_arbiter

Overview:
- Round-robin arbiter that shares the 8:1 single-bit mux datapath between 8 requesters.
- Owns the 3-bit mux select and a one-hot grant vector.
- Holds each grant for the duration of a requester's transfer, optionally bounded by a burst limit.
- Drives the mux select so the selected source bit appears on data_out while the grant is valid.

Parameters:
- MAX_HOLD, 4: max consecutive BUSY cycles one owner keeps the mux while other requests are pending (only with MUX_ARB_TIMEOUT_EN); legal range 1..15.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- req  input  8  request vector; req[i] is held high by requester i for the length of its transfer.
- data_in  input  8  per-source data bits; data_in[i] belongs to requester i.
- grant  output  8  one-hot grant, registered; all-zero when idle.
- sel  output  3  registered mux select = index of the granted requester; holds its last value when idle.
- valid  output  1  registered; high in BUSY, i.e. exactly when grant != 0.
- data_out  output  1  data_in[sel] when valid = 1, else 0 (combinational mux of registered sel).

Behaviour:
- Reset, sampled at the clock edge:
  - state = IDLE, grant = 0, sel = 0, valid = 0, ptr = 0, hold_cnt = 0.
  - data_out = 0 as a consequence.
  - Reset asserted during BUSY drops grant and valid at that same edge; no transfer completion is signalled.
- ptr (3 bits) is the round-robin start index. Arbitration picks the first i with req[i] = 1, scanning ptr, ptr+1, ..., ptr+7 (mod 8). Wrap-around is required, e.g. ptr = 6 with req = 0x03 grants index 0.
- IDLE:
  - If req != 0 at edge N, then at edge N go BUSY: sel = winner, grant = 1<<winner, valid = 1, hold_cnt = 0.
  - Grant latency is one cycle: a request first seen high in cycle N produces a visible grant in cycle N+1.
  - If req = 0, stay IDLE.
- BUSY: owner is o = sel.
  - Release condition: req[o] = 0 at the edge.
  - On release, re-arbitrate in the same edge with ptr = o+1, excluding o:
    - winner exists: back-to-back handoff, grant switches with no idle cycle, hold_cnt = 0.
    - no winner: go IDLE, grant = 0, valid = 0.
  - ptr is updated to o+1 (mod 8) at every release and every forced release.
  - No release: grant and sel are unchanged; hold_cnt increments and saturates at MAX_HOLD-1.
- Fairness: the granted index can change only at a release or a forced release. An owner is never re-granted ahead of another pending requester that follows it in round-robin order.
- Simultaneous events:
  - Several new requests in the same cycle: the lowest round-robin distance from ptr wins.
  - Owner dropping req in the same cycle that others raise req: normal handoff.
  - req changes of non-owners during BUSY have no effect until the next release.
- Invariants: grant is always 0 or one-hot; grant[sel] = 1 whenever valid = 1.

Optional Feature:
- MUX_ARB_TIMEOUT_EN defined:
  - In BUSY, if hold_cnt = MAX_HOLD-1 and any req[j] = 1 with j != o, force a release at that edge, even though req[o] = 1.
  - Re-arbitration excludes o, ptr = o+1.
  - o must re-win through normal rotation.
  - If no other request is pending, o keeps the grant and hold_cnt stays saturated.
- Not defined: no forced release; an owner holds the mux until it drops req. hold_cnt logic may be removed.

Test Plan:
- Reset then req = 0x00 for 5 cycles -> grant = 0, sel = 0, valid = 0, data_out = 0 every cycle.
- req = 0x10 asserted in cycle 2 with data_in = 0x10 -> cycle 3: grant = 0x10, sel = 4, valid = 1, data_out = 1. Drop req in cycle 6 -> cycle 7: grant = 0, valid = 0.
- req = 0xFF held; each owner drops req for one cycle when granted -> grants rotate 0,1,...,7,0 with no idle cycles between handoffs.
- ptr = 6 (after a grant to 5), then req = 0x03 -> grant = 0x01, sel = 0 (wrap-around).
- With MUX_ARB_TIMEOUT_EN and MAX_HOLD = 4: req = 0x01 then req = 0x05 held -> index 0 owns for exactly 4 cycles, then grant = 0x04 on the next cycle. Without the macro -> index 0 keeps the grant indefinitely.
- Assert rst for one cycle while grant = 0x08 -> next cycle grant = 0, valid = 0, sel = 0. Then req = 0x08 still high -> regranted one cycle after rst deasserts.

Source files
------------

// File: rtl/mux8_rr_arbiter.sv
// Round-robin arbiter that owns the select of an 8:1 single-bit mux and grants it to one requester at a time.
// Optional feature: define MUX_ARB_TIMEOUT_EN to force a release after MAX_HOLD busy cycles while others wait.
module mux8_rr_arbiter #(
  parameter int MAX_HOLD = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] req,
  input  logic [7:0] data_in,
  output logic [7:0] grant,
  output logic [2:0] sel,
  output logic       valid,
  output logic       data_out
);

  typedef enum logic {IDLE, BUSY} state_t;

  localparam logic [3:0] HoldMax = 4'(MAX_HOLD - 1);

  state_t     r_state, w_nextState;
  logic [7:0] r_grant, w_nextGrant;
  logic [2:0] r_sel, w_nextSel;
  logic [2:0] r_ptr, w_nextPtr;
  logic       r_valid, w_nextValid;
  logic [3:0] r_holdCnt, w_nextHoldCnt;

  logic [7:0] w_ownerMask;
  logic [7:0] w_candidates;
  logic [2:0] w_base;
  logic [2:0] w_scanIdx;
  logic [2:0] w_winner;
  logic       w_found;
  logic       w_release;
  logic       w_forced;

  // In BUSY the current owner is never a candidate and the scan starts just after it.
  assign w_ownerMask  = (r_state == BUSY) ? (8'd1 << r_sel) : 8'd0;
  assign w_candidates = req & ~w_ownerMask;
  assign w_base       = (r_state == BUSY) ? (r_sel + 3'd1) : r_ptr;

  // Scan farthest-first so the candidate nearest to w_base overwrites the others.
  always_comb begin
    w_found   = 1'b0;
    w_winner  = 3'd0;
    w_scanIdx = 3'd0;
    for (int k = 7; k >= 0; k--) begin
      w_scanIdx = w_base + 3'(k);
      if (w_candidates[w_scanIdx]) begin
        w_found  = 1'b1;
        w_winner = w_scanIdx;
      end
    end
  end

  assign w_release = (r_state == BUSY) && !req[r_sel];

`ifdef MUX_ARB_TIMEOUT_EN
  assign w_forced = (r_state == BUSY) && req[r_sel] && (r_holdCnt == HoldMax) &&
                    (w_candidates != 8'd0);
`else
  assign w_forced = 1'b0;
`endif

  always_comb begin
    w_nextState   = r_state;
    w_nextGrant   = r_grant;
    w_nextSel     = r_sel;
    w_nextValid   = r_valid;
    w_nextPtr     = r_ptr;
    w_nextHoldCnt = r_holdCnt;
    case (r_state)
      IDLE: begin
        if (w_found) begin
          w_nextState   = BUSY;
          w_nextGrant   = 8'd1 << w_winner;
          w_nextSel     = w_winner;
          w_nextValid   = 1'b1;
          w_nextHoldCnt = 4'd0;
        end
      end
      BUSY: begin
        if (w_release || w_forced) begin
          w_nextPtr = r_sel + 3'd1;
          if (w_found) begin
            w_nextGrant   = 8'd1 << w_winner;
            w_nextSel     = w_winner;
            w_nextHoldCnt = 4'd0;
          end else begin
            w_nextState = IDLE;
            w_nextGrant = 8'd0;
            w_nextValid = 1'b0;
          end
        end else if (r_holdCnt < HoldMax) begin
          w_nextHoldCnt = r_holdCnt + 4'd1;
        end
      end
      default: w_nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_grant   <= 8'd0;
      r_sel     <= 3'd0;
      r_valid   <= 1'b0;
      r_ptr     <= 3'd0;
      r_holdCnt <= 4'd0;
    end else begin
      r_state   <= w_nextState;
      r_grant   <= w_nextGrant;
      r_sel     <= w_nextSel;
      r_valid   <= w_nextValid;
      r_ptr     <= w_nextPtr;
      r_holdCnt <= w_nextHoldCnt;
    end
  end

  assign grant    = r_grant;
  assign sel      = r_sel;
  assign valid    = r_valid;
  assign data_out = r_valid ? data_in[r_sel] : 1'b0;

endmodule

// File: tb/tb_mux8_rr_arbiter.sv
// Bench for mux8_rr_arbiter: literal scenario checks plus a cycle-by-cycle behavioural model under random traffic.
module tb_mux8_rr_arbiter;

  localparam int MAX_HOLD = 4;
`ifdef MUX_ARB_TIMEOUT_EN
  localparam bit TIMEOUT = 1'b1;
`else
  localparam bit TIMEOUT = 1'b0;
`endif

  logic       clk;
  logic       rst;
  logic [7:0] req;
  logic [7:0] data_in;
  logic [7:0] grant;
  logic [2:0] sel;
  logic       valid;
  logic       data_out;

  int checks = 0;
  int errors = 0;

  // Model state: owner index or -1 when idle, last select, rotation start, busy cycles held.
  int  mOwner = -1;
  int  mSel   = 0;
  int  mPtr   = 0;
  int  mHold  = 0;
  bit  modelLive = 1'b0;

  mux8_rr_arbiter #(.MAX_HOLD(MAX_HOLD)) dut (
    .clk(clk), .rst(rst), .req(req), .data_in(data_in),
    .grant(grant), .sel(sel), .valid(valid), .data_out(data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int pick(input logic [7:0] r, input int start, input int excl);
    for (int d = 0; d < 8; d++) begin
      int i;
      i = (start + d) % 8;
      if (i != excl && r[i]) return i;
    end
    return -1;
  endfunction

  // Reference arbiter: evaluates the round-robin rules on every rising edge.
  always @(posedge clk) begin
    int w;
    bit forced;
    modelLive = 1'b1;
    if (rst) begin
      mOwner = -1; mSel = 0; mPtr = 0; mHold = 0;
    end else if (mOwner < 0) begin
      w = pick(req, mPtr, -1);
      if (w >= 0) begin
        mOwner = w; mSel = w; mHold = 0;
      end
    end else begin
      forced = TIMEOUT && req[mOwner] && (mHold == MAX_HOLD - 1) &&
               ((req & ~(8'd1 << mOwner)) != 8'd0);
      if (!req[mOwner] || forced) begin
        mPtr = (mOwner + 1) % 8;
        w = pick(req, mPtr, mOwner);
        if (w >= 0) begin
          mOwner = w; mSel = w; mHold = 0;
        end else begin
          mOwner = -1;
        end
      end else if (mHold < MAX_HOLD - 1) begin
        mHold = mHold + 1;
      end
    end
  end

  // Compare every cycle, half a period after the edge.
  always @(negedge clk) begin
    logic [7:0] expGrant;
    logic       expValid;
    logic       expOut;
    if (modelLive) begin
      expGrant = (mOwner < 0) ? 8'd0 : (8'd1 << mOwner);
      expValid = (mOwner >= 0);
      expOut   = expValid ? data_in[mSel] : 1'b0;
      checks++;
      if (grant !== expGrant) begin
        errors++;
        $display("[TB] FAIL model_grant t=%0t got %h want %h", $time, grant, expGrant);
      end
      checks++;
      if (valid !== expValid) begin
        errors++;
        $display("[TB] FAIL model_valid t=%0t got %b want %b", $time, valid, expValid);
      end
      checks++;
      if (sel !== 3'(mSel)) begin
        errors++;
        $display("[TB] FAIL model_sel t=%0t got %0d want %0d", $time, sel, mSel);
      end
      checks++;
      if (data_out !== expOut) begin
        errors++;
        $display("[TB] FAIL model_data_out t=%0t got %b want %b", $time, data_out, expOut);
      end
    end
  end

  // Drive one cycle of inputs and return shortly after the edge that samples them.
  task automatic applyStimulus(input logic r, input logic [7:0] q, input logic [7:0] d);
    rst = r;
    req = q;
    data_in = d;
    @(posedge clk);
    #2;
  endtask

  task automatic checkOutput(input string name, input logic [7:0] g, input logic [2:0] s,
                             input logic v, input logic o);
    checks++;
    if (grant !== g || sel !== s || valid !== v || data_out !== o) begin
      errors++;
      $display("[TB] FAIL %s: got grant=%h sel=%0d valid=%b data_out=%b want grant=%h sel=%0d valid=%b data_out=%b",
               name, grant, sel, valid, data_out, g, s, v, o);
    end
  endtask

  initial begin
    logic [7:0] r;
    rst = 1'b1;
    req = 8'h00;
    data_in = 8'h00;

    $display("[TB] reset and idle");
    applyStimulus(1'b1, 8'h00, 8'h00);
    checkOutput("reset", 8'h00, 3'd0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b0, 8'h00, 8'hFF);
      checkOutput("idle", 8'h00, 3'd0, 1'b0, 1'b0);
    end

    $display("[TB] single requester");
    applyStimulus(1'b0, 8'h10, 8'h10);
    checkOutput("grant4", 8'h10, 3'd4, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 8'h10, 8'h00);
      checkOutput("hold4", 8'h10, 3'd4, 1'b1, 1'b0);
    end
    applyStimulus(1'b0, 8'h00, 8'h10);
    checkOutput("release4", 8'h00, 3'd4, 1'b0, 1'b0);

    $display("[TB] full rotation");
    applyStimulus(1'b1, 8'h00, 8'h00);
    applyStimulus(1'b0, 8'hFF, 8'hAA);
    checkOutput("rot_first", 8'h01, 3'd0, 1'b1, 1'b0);
    for (int k = 0; k < 8; k++) begin
      int n;
      n = (k + 1) % 8;
      r = 8'hFF & ~(8'd1 << k);
      applyStimulus(1'b0, r, 8'hAA);
      checkOutput("rotate", 8'd1 << n, 3'(n), 1'b1, n[0]);
    end

    $display("[TB] wrap-around");
    applyStimulus(1'b1, 8'h00, 8'h00);
    applyStimulus(1'b0, 8'h20, 8'h00);
    checkOutput("grant5", 8'h20, 3'd5, 1'b1, 1'b0);
    applyStimulus(1'b0, 8'h00, 8'h00);
    applyStimulus(1'b0, 8'h03, 8'h01);
    checkOutput("wrap", 8'h01, 3'd0, 1'b1, 1'b1);
    applyStimulus(1'b0, 8'h00, 8'h00);

    $display("[TB] hold limit");
    applyStimulus(1'b1, 8'h00, 8'h00);
    applyStimulus(1'b0, 8'h01, 8'h00);
    checkOutput("own0", 8'h01, 3'd0, 1'b1, 1'b0);
    for (int i = 1; i < MAX_HOLD; i++) begin
      applyStimulus(1'b0, 8'h05, 8'h00);
      checkOutput("own0_held", 8'h01, 3'd0, 1'b1, 1'b0);
    end
    applyStimulus(1'b0, 8'h05, 8'h00);
    if (TIMEOUT) checkOutput("forced", 8'h04, 3'd2, 1'b1, 1'b0);
    else         checkOutput("no_force", 8'h01, 3'd0, 1'b1, 1'b0);

    $display("[TB] reset while busy");
    applyStimulus(1'b1, 8'h00, 8'h00);
    applyStimulus(1'b0, 8'h08, 8'h08);
    checkOutput("own3", 8'h08, 3'd3, 1'b1, 1'b1);
    applyStimulus(1'b1, 8'h08, 8'h08);
    checkOutput("busy_reset", 8'h00, 3'd0, 1'b0, 1'b0);
    applyStimulus(1'b0, 8'h08, 8'h08);
    checkOutput("regrant3", 8'h08, 3'd3, 1'b1, 1'b1);

    $display("[TB] random traffic");
    r = 8'h00;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(3) == 0) r = 8'($urandom);
      else r[$urandom_range(7)] = ~r[$urandom_range(7)];
      applyStimulus(($urandom_range(63) == 0), r, 8'($urandom));
    end

    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
